// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ID/EX packet, ALU ops, opcodes and decode helpers for the RV64I core
package pipeline_pkg;
   localparam int RV_XLEN = 64;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;
   typedef enum logic [0:0] {RUN = ST_RUN, DRAIN = ST_DRAIN} id_state_e;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC
   } alu_op_e;
   typedef struct packed {
      logic               valid;
      logic [RV_XLEN-1:0] pc;
      logic [RV_XLEN-1:0] imm;
      logic [RV_XLEN-1:0] rs1_data;
      logic [RV_XLEN-1:0] rs2_data;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      alu_op_e            alu_op;
      logic               is_word;
      logic               is_load;
      logic               is_store;
      logic               is_branch;
      logic               is_jal;
      logic               is_jalr;
      logic               wb_en;
      logic [1:0]         mem_size;
      logic               mem_unsigned;
      logic               illegal;
   } IDEX_Pipe_t;
   function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
   function automatic logic is_fence_op(input logic [31:0] instr);
      return instr[6:0] == OP_FENCE && instr[14:13] == 2'b00;
   endfunction
endpackage

// File: rtl/rv64i_decoder.sv
// rv64i_decoder: combinational RV64I decode of one instruction word into ID/EX packet fields
module rv64i_decoder
   import pipeline_pkg::*;
(
   input  logic [31:0] instr,
   output IDEX_Pipe_t  pkt,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        is_fence,
   output logic        illegal
);
   logic [6:0] op, f7;
   logic [5:0] f6;
   logic [2:0] f3;
   logic [RV_XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f6 = instr[31:26];
   assign f7 = instr[31:25];
   assign i_imm = {{52{instr[31]}}, instr[31:20]};
   assign s_imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign b_imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign j_imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   always_comb begin
      pkt = '0;
      pkt.rs1 = instr[19:15];
      pkt.rs2 = instr[24:20];
      pkt.rd = instr[11:7];
      pkt.alu_op = ALU_ADD;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      is_fence = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_LUI:    begin pkt.imm = u_imm; pkt.alu_op = ALU_LUI; pkt.wb_en = 1'b1; end
         OP_AUIPC:  begin pkt.imm = u_imm; pkt.alu_op = ALU_AUIPC; pkt.wb_en = 1'b1; end
         OP_JAL:    begin pkt.imm = j_imm; pkt.is_jal = 1'b1; pkt.wb_en = 1'b1; end
         OP_JALR:   begin illegal = f3 != 3'd0; pkt.imm = i_imm; pkt.is_jalr = 1'b1; pkt.wb_en = 1'b1; uses_rs1 = 1'b1; end
         OP_BRANCH: begin
            illegal = f3[2:1] == 2'b01;
            pkt.imm = b_imm;
            pkt.is_branch = 1'b1;
            pkt.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_LOAD:   begin
            illegal = f3 == 3'd7;
            pkt.imm = i_imm;
            pkt.is_load = 1'b1;
            pkt.wb_en = 1'b1;
            pkt.mem_size = f3[1:0];
            pkt.mem_unsigned = f3[2];
            uses_rs1 = 1'b1;
         end
         OP_STORE:  begin
            illegal = f3[2];
            pkt.imm = s_imm;
            pkt.is_store = 1'b1;
            pkt.mem_size = f3[1:0];
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_IMM:    begin
            illegal = (f3 == 3'd1 && f6 != 6'd0) || (f3 == 3'd5 && f6 != 6'd0 && f6 != 6'b010000);
            pkt.imm = i_imm;
            pkt.alu_op = alu_f3(f3, f3 == 3'd5 && instr[30]);
            pkt.wb_en = 1'b1;
            uses_rs1 = 1'b1;
         end
         OP_IMM32:  begin
            illegal = !(f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'd0) || (f3 == 3'd5 && (f7 == 7'd0 || f7 == 7'b0100000)));
            pkt.imm = i_imm;
            pkt.alu_op = alu_f3(f3, f3 == 3'd5 && instr[30]);
            pkt.is_word = 1'b1;
            pkt.wb_en = 1'b1;
            uses_rs1 = 1'b1;
         end
         OP_OP:     begin
            illegal = !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
            pkt.alu_op = alu_f3(f3, instr[30]);
            pkt.wb_en = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_OP32:   begin
            illegal = !(((f3 == 3'd0 || f3 == 3'd5) && (f7 == 7'd0 || f7 == 7'b0100000)) || (f3 == 3'd1 && f7 == 7'd0));
            pkt.alu_op = alu_f3(f3, instr[30]);
            pkt.is_word = 1'b1;
            pkt.wb_en = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_FENCE:  begin illegal = f3[2:1] != 2'b00; is_fence = f3[2:1] == 2'b00; end
         OP_SYSTEM: illegal = !(instr == 32'h0000_0073 || instr == 32'h0010_0073);
         default:   illegal = 1'b1;
      endcase
      // undecodable words travel down the pipe as a side-effect-free nop
      if (illegal) begin
         pkt = '0;
         uses_rs1 = 1'b0;
         uses_rs2 = 1'b0;
      end
      pkt.illegal = illegal;
   end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV64I decode stage with fetch slot, load-use stall, fence drain and regfile read
module id_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          fetch_valid_i,
   input  logic [XLEN-1:0]               fetch_pc_i,
   input  logic [31:0]                   fetch_instr_i,
   output logic                          fetch_ready_o,
   input  logic                          flush_i,
   input  logic                          ex_is_load_i,
   input  logic [4:0]                    ex_rd_i,
   output logic [4:0]                    rs1_addr_o,
   output logic [4:0]                    rs2_addr_o,
   input  logic [XLEN-1:0]               rs1_data_i,
   input  logic [XLEN-1:0]               rs2_data_i,
   input  logic                          wb_we_i,
   input  logic [4:0]                    wb_rd_i,
   input  logic [XLEN-1:0]               wb_data_i,
   output logic [$bits(IDEX_Pipe_t)-1:0] data_o,
   output logic                          stall_o,
   output logic                          illegal_o,
   output logic [63:0]                   issued_cnt_o
);
   localparam int CW = DRAIN_CYCLES < 2 ? 1 : $clog2(DRAIN_CYCLES + 1);
   id_state_e state;
   logic [CW-1:0] drain_cnt;
   logic slot_valid;
   logic [XLEN-1:0] slot_pc;
   logic [31:0] slot_instr;
   IDEX_Pipe_t dec, pkt;
   logic uses_rs1, uses_rs2, is_fence, dec_illegal, hazard, issue, accept;
   rv64i_decoder u_dec (
      .instr    (slot_instr),
      .pkt      (dec),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2),
      .is_fence (is_fence),
      .illegal  (dec_illegal)
   );
   assign rs1_addr_o = slot_instr[19:15];
   assign rs2_addr_o = slot_instr[24:20];
   assign hazard = ex_is_load_i && ex_rd_i != 5'd0 &&
                   ((uses_rs1 && rs1_addr_o == ex_rd_i) || (uses_rs2 && rs2_addr_o == ex_rd_i));
   assign issue = slot_valid && !hazard && state == RUN && !flush_i && !(is_fence && drain_cnt != '0);
   assign fetch_ready_o = !slot_valid || issue;
   assign accept = fetch_valid_i && fetch_ready_o && !flush_i;
   assign stall_o = slot_valid && !issue;
   assign illegal_o = issue && dec_illegal;
   always_comb begin
      pkt = dec;
      pkt.valid = issue;
      pkt.pc = slot_pc;
      pkt.rs1_data = rs1_addr_o == 5'd0 ? '0 : (wb_we_i && wb_rd_i == rs1_addr_o) ? wb_data_i : rs1_data_i;
      pkt.rs2_data = rs2_addr_o == 5'd0 ? '0 : (wb_we_i && wb_rd_i == rs2_addr_o) ? wb_data_i : rs2_data_i;
   end
   assign data_o = slot_valid ? pkt : '0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= RUN;
         drain_cnt <= '0;
         slot_valid <= 1'b0;
         slot_pc <= '0;
         slot_instr <= '0;
         issued_cnt_o <= '0;
      end else begin
         if (flush_i) slot_valid <= 1'b0;
         else if (fetch_ready_o) slot_valid <= fetch_valid_i;
         if (accept) begin
            slot_pc <= fetch_pc_i;
            slot_instr <= fetch_instr_i;
         end
         if (issue) issued_cnt_o <= issued_cnt_o + 64'd1;
         // the drain window starts when the fence is captured, so it issues DRAIN_CYCLES later
         if (flush_i) begin
            state <= RUN;
            drain_cnt <= '0;
         end else if (state == DRAIN) begin
            state <= (drain_cnt <= CW'(1)) ? RUN : DRAIN;
            drain_cnt <= drain_cnt == '0 ? '0 : drain_cnt - CW'(1);
         end else if (accept && is_fence_op(fetch_instr_i)) begin
            state <= DRAIN;
            drain_cnt <= CW'(DRAIN_CYCLES);
         end
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed expectations
module tb_id_stage;
   import pipeline_pkg::*;
   localparam logic [31:0] I_ADDI1 = 32'h0050_0093;
   localparam logic [31:0] I_LD    = 32'h0001_3283;
   localparam logic [31:0] I_ADDLU = 32'h0012_8333;
   localparam logic [31:0] I_FENCE = 32'h0ff0_000f;
   localparam logic [31:0] I_ADDI2 = 32'h0070_0113;
   localparam logic [31:0] I_ADDX1 = 32'h0010_8333;
   localparam logic [31:0] I_ILL   = 32'h0000_007f;
   localparam logic [31:0] I_SLLIW = 32'h0200_909b;
   logic clk_i, rst_ni, fetch_valid_i, fetch_ready_o, flush_i, ex_is_load_i, wb_we_i;
   logic stall_o, illegal_o;
   logic [63:0] fetch_pc_i, rs1_data_i, rs2_data_i, wb_data_i, issued_cnt_o, pc;
   logic [31:0] fetch_instr_i;
   logic [4:0] ex_rd_i, rs1_addr_o, rs2_addr_o, wb_rd_i;
   logic [$bits(IDEX_Pipe_t)-1:0] data_o;
   IDEX_Pipe_t d;
   int errors, checks;
   assign d = data_o;
   id_stage dut (
      .clk_i, .rst_ni, .fetch_valid_i, .fetch_pc_i, .fetch_instr_i, .fetch_ready_o,
      .flush_i, .ex_is_load_i, .ex_rd_i, .rs1_addr_o, .rs2_addr_o, .rs1_data_i, .rs2_data_i,
      .wb_we_i, .wb_rd_i, .wb_data_i, .data_o, .stall_o, .illegal_o, .issued_cnt_o
   );
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask
   task automatic fetch(input logic [31:0] ins);
      fetch_valid_i = 1'b1;
      fetch_instr_i = ins;
      fetch_pc_i = pc;
      pc = pc + 64'd4;
   endtask
   initial begin
      errors = 0; checks = 0; pc = 64'h8000_0000;
      rst_ni = 1'b0; flush_i = 1'b0; ex_is_load_i = 1'b0; ex_rd_i = '0;
      rs1_data_i = '0; rs2_data_i = '0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      fetch_valid_i = 1'b1; fetch_instr_i = I_ADDI1; fetch_pc_i = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_data", 64'(|data_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_ready", 64'(fetch_ready_o), 64'd1);
      chk("rst_illegal", 64'(illegal_o), 64'd0);
      chk("rst_cnt", issued_cnt_o, 64'd0);
      rst_ni = 1'b1;
      fetch(I_ADDI1);
      #1 chk("c0_ready", 64'(fetch_ready_o), 64'd1);
      cyc();
      fetch(I_LD); rs1_data_i = 64'hffff;
      @(negedge clk_i);
      chk("addi_valid", 64'(d.valid), 64'd1);
      chk("addi_rd", 64'(d.rd), 64'd1);
      chk("addi_imm", d.imm, 64'd5);
      chk("addi_pc", d.pc, 64'h8000_0000);
      chk("addi_x0", d.rs1_data, 64'd0);
      chk("addi_stall", 64'(stall_o), 64'd0);
      chk("addi_cnt_pre", issued_cnt_o, 64'd0);
      cyc();
      fetch(I_ADDLU); rs1_data_i = '0;
      @(negedge clk_i);
      chk("addi_cnt", issued_cnt_o, 64'd1);
      chk("ld_is_load", 64'(d.is_load), 64'd1);
      chk("ld_rd", 64'(d.rd), 64'd5);
      chk("ld_size", 64'(d.mem_size), 64'd3);
      cyc();
      fetch_valid_i = 1'b0; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
      @(negedge clk_i);
      chk("hz_stall", 64'(stall_o), 64'd1);
      chk("hz_ready", 64'(fetch_ready_o), 64'd0);
      chk("hz_valid", 64'(d.valid), 64'd0);
      chk("hz_cnt", issued_cnt_o, 64'd2);
      cyc();
      ex_is_load_i = 1'b0; fetch(I_FENCE);
      @(negedge clk_i);
      chk("add_valid", 64'(d.valid), 64'd1);
      chk("add_rd", 64'(d.rd), 64'd6);
      chk("add_rs1", 64'(d.rs1), 64'd5);
      chk("add_stall", 64'(stall_o), 64'd0);
      chk("add_cnt", issued_cnt_o, 64'd2);
      cyc();
      fetch(I_ADDI2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("fence_stall", 64'(stall_o), 64'd1);
         chk("fence_ready", 64'(fetch_ready_o), 64'd0);
         cyc();
      end
      @(negedge clk_i);
      chk("fence_valid", 64'(d.valid), 64'd1);
      chk("fence_wb", 64'(d.wb_en), 64'd0);
      chk("fence_stall_end", 64'(stall_o), 64'd0);
      chk("fence_ready_end", 64'(fetch_ready_o), 64'd1);
      cyc();
      fetch(I_ADDLU);
      @(negedge clk_i);
      chk("addi2_valid", 64'(d.valid), 64'd1);
      chk("addi2_imm", d.imm, 64'd7);
      chk("addi2_cnt", issued_cnt_o, 64'd4);
      cyc();
      ex_is_load_i = 1'b1; ex_rd_i = 5'd5; flush_i = 1'b1; fetch(I_ADDI1);
      @(negedge clk_i);
      chk("fl_stall", 64'(stall_o), 64'd1);
      chk("fl_valid", 64'(d.valid), 64'd0);
      cyc();
      flush_i = 1'b0; ex_is_load_i = 1'b0; fetch(I_ADDX1);
      @(negedge clk_i);
      chk("fl_empty", 64'(|data_o), 64'd0);
      chk("fl_ready", 64'(fetch_ready_o), 64'd1);
      chk("fl_cnt", issued_cnt_o, 64'd5);
      cyc();
      fetch(I_ILL); wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 64'h1234;
      @(negedge clk_i);
      chk("byp_valid", 64'(d.valid), 64'd1);
      chk("byp_rs1", d.rs1_data, 64'h1234);
      chk("byp_rs2", d.rs2_data, 64'h1234);
      chk("byp_addr", 64'(rs1_addr_o), 64'd1);
      wb_rd_i = 5'd0; rs1_data_i = 64'h55; rs2_data_i = 64'h66;
      #1;
      chk("rf_rs1", d.rs1_data, 64'h55);
      chk("rf_rs2", d.rs2_data, 64'h66);
      cyc();
      fetch(I_SLLIW); wb_we_i = 1'b0; rs1_data_i = '0; rs2_data_i = '0;
      @(negedge clk_i);
      chk("ill_valid", 64'(d.valid), 64'd1);
      chk("ill_flag", 64'(illegal_o), 64'd1);
      chk("ill_wb", 64'(d.wb_en), 64'd0);
      cyc();
      fetch(I_ADDI1);
      @(negedge clk_i);
      chk("slliw_flag", 64'(illegal_o), 64'd1);
      chk("slliw_wb", 64'(d.wb_en), 64'd0);
      cyc();
      fetch(I_FENCE);
      @(negedge clk_i);
      chk("ill_clear", 64'(illegal_o), 64'd0);
      chk("ill_clear_wb", 64'(d.wb_en), 64'd1);
      cyc();
      fetch_valid_i = 1'b0;
      @(negedge clk_i);
      chk("dr_stall", 64'(stall_o), 64'd1);
      chk("dr_cnt", issued_cnt_o, 64'd9);
      cyc();
      @(negedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      chk("ar_data", 64'(|data_o), 64'd0);
      chk("ar_stall", 64'(stall_o), 64'd0);
      chk("ar_ready", 64'(fetch_ready_o), 64'd1);
      chk("ar_cnt", issued_cnt_o, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1; fetch(I_ADDI1); ex_is_load_i = 1'b1; ex_rd_i = 5'd0;
      cyc();
      fetch_valid_i = 1'b0;
      @(negedge clk_i);
      chk("x0_nohz_valid", 64'(d.valid), 64'd1);
      chk("x0_nohz_stall", 64'(stall_o), 64'd0);
      cyc();
      @(negedge clk_i);
      chk("post_cnt", issued_cnt_o, 64'd1);
      chk("post_empty", 64'(|data_o), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the RV64I five-stage core: owns the fetched-instruction slot, decodes RV64I, reads the register file and drives the ID/EX pipeline register.
- Detects load-use hazards against the instruction in EX and stalls on them.
- Serialises FENCE/FENCE.I by draining the back end.
- Drops its slot on branch/jump redirect from EX.

Parameters:
XLEN, 64, datapath width
DRAIN_CYCLES, 3, cycles a FENCE/FENCE.I waits in the slot before issue (covers EX, MEM, WB)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fetch_valid_i  in  1  fetch packet valid
fetch_pc_i  in  XLEN  fetch PC
fetch_instr_i  in  32  fetch instruction word
fetch_ready_o  out  1  slot can accept this cycle
flush_i  in  1  redirect from EX; kill slot and incoming fetch
ex_is_load_i  in  1  instruction currently in EX is a load
ex_rd_i  in  5  rd of instruction in EX
rs1_addr_o  out  5  regfile read port 1 address
rs2_addr_o  out  5  regfile read port 2 address
rs1_data_i  in  XLEN  regfile read data 1, combinational
rs2_data_i  in  XLEN  regfile read data 2, combinational
wb_we_i  in  1  writeback enable
wb_rd_i  in  5  writeback destination
wb_data_i  in  XLEN  writeback data
data_o  out  $bits(IDEX_Pipe_t)  decoded packet to IDEX data_i
stall_o  out  1  to IDEX stall_i; high inserts a bubble
illegal_o  out  1  issuing instruction is undecodable
issued_cnt_o  out  64  count of issued instructions

Behaviour:
Reset values (asynchronous, rst_ni low):
- Slot empty, FSM in RUN, drain counter 0, issued_cnt_o 0.
- Outputs while in reset: data_o all-zero, stall_o 0, illegal_o 0, fetch_ready_o 1.

Slot:
- Holds slot_valid, slot_pc, slot_instr.
- Load when fetch_valid_i && fetch_ready_o && !flush_i.
- fetch_ready_o = !slot_valid || issue.
- The slot is the only ID storage, so fetch-to-IDEX latency is one cycle.

Issue:
- issue = slot_valid && !hazard && state==RUN && !flush_i && !(is_fence && drain_cnt!=0).
- When issue: data_o is the decoded packet with valid=1, stall_o=0, and issued_cnt_o increments (wraps at 2^64).
- When slot_valid && !issue: stall_o=1 and data_o.valid=0.
- When the slot is empty: data_o all-zero, stall_o=0.

Load-use hazard:
- hazard = ex_is_load_i && ex_rd_i!=0 && ((uses_rs1 && rs1==ex_rd_i) || (uses_rs2 && rs2==ex_rd_i)).
- uses_rs1/uses_rs2 come from the instruction format: LUI, AUIPC and JAL use neither rs1 nor rs2.
- Lasts exactly one cycle, because the bubble follows the load into EX.

FENCE FSM:
- States: RUN and DRAIN.
- RUN -> DRAIN when a FENCE/FENCE.I enters the slot; drain_cnt is loaded with DRAIN_CYCLES.
- In DRAIN, drain_cnt decrements each cycle; at 0 -> RUN and the fence issues as a nop (wb_en=0).
- flush_i in any state -> RUN, drain_cnt=0, slot empty next cycle.

Register read:
- rs*_addr_o come from slot_instr.
- WB bypass: if wb_we_i && wb_rd_i!=0 && wb_rd_i==rs*, use wb_data_i.
- Register x0 always reads 0.

Immediates:
- I/S/B/U/J immediates are sign-extended to XLEN.
- OP-32/OP-IMM-32 set is_word.
- SLLI/SRLI/SRAI use a 6-bit shamt; for the *W forms, shamt[5]=1 is illegal.

Illegal instructions:
- Unknown opcode/funct: issues as a nop with illegal_o=1 for that issue cycle only.

Simultaneous events:
- flush_i wins over issue, fetch acceptance and hazard.
- Fetch acceptance in the same cycle as issue is allowed (back-to-back flow).

Decomposition:
pipeline_pkg contains:
- IDEX_Pipe_t: valid, pc, imm, rs1_data, rs2_data, rs1, rs2, rd, alu_op, is_word, is_load, is_store, is_branch, is_jal, is_jalr, wb_en, mem_size[1:0], mem_unsigned, illegal.
- alu_op_e enum.
- Opcode localparams.
- id_state_e {RUN, DRAIN}.

One sub-module, rv64i_decoder: purely combinational, maps instr to packet fields, uses_rs1/uses_rs2, is_fence and illegal. id_stage keeps the slot, FSM, hazard logic, bypass and counter.

Test Plan:
1. Reset then ADDI x1,x0,5 (0x00500093) at PC 0x80000000 -> next cycle data_o.valid=1, rd=1, imm=5, stall_o=0; issued_cnt_o=1.
2. LD x5,0(x2) (0x00013283) issued, then ADD x6,x5,x1 (0x00128333) with ex_is_load_i=1, ex_rd_i=5 -> one cycle with stall_o=1 and fetch_ready_o=0, ADD issues the following cycle.
3. FENCE (0x0ff0000f) enters slot -> stall_o=1 for 3 cycles, then it issues with wb_en=0; a following ADDI issues one cycle later.
4. flush_i asserted while slot holds an instruction in hazard and fetch_valid_i=1 -> slot empty next cycle, nothing issued, state RUN.
5. wb_we_i=1, wb_rd_i=1, wb_data_i=0x1234 while slot holds ADD x6,x1,x1 and rs1_data_i=0 -> data_o.rs1_data=rs2_data=0x1234; repeat with wb_rd_i=0 -> regfile data used.
6. Opcode 0x7F word, and SLLIW with shamt[5]=1 -> each issues with illegal_o=1, wb_en=0; assert rst_ni low mid-DRAIN -> all outputs at reset values immediately.
